// File: rtl/dm_pkg.sv
// dm_pkg: shared types and default widths for the DM load/store unit.
//   state_t    : LSU sequencer states
//   DM_AW/DW   : default address/data widths of the DM port
//   DM_LENW    : default burst-length field width (beats = len+1)
//   RD_LAT_MAX : largest supported DM read latency
package dm_pkg;

  localparam int unsigned DM_AW      = 8;
  localparam int unsigned DM_DW      = 8;
  localparam int unsigned DM_LENW    = 4;
  localparam int unsigned RD_LAT_MAX = 3;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dm_rd_delay.sv
// dm_rd_delay: turns the read-issue pulse into the read-data capture strobe,
// LAT cycles later (LAT=0 passes the issue pulse straight through).
//   clk, reset : clock and async active-low reset
//   issue      : high in the cycle dm_mem_read is driven
//   capture_c  : high in the cycle whose end samples dm_read_data
module dm_rd_delay #(
  parameter int unsigned LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  output logic capture_c
);

  localparam int unsigned DEPTH = (LAT == 0) ? 1 : LAT;

  logic [DEPTH-1:0] sr_q;

  // Valid shift register: bit k set means the issue happened k+1 cycles ago.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= (sr_q << 1) | DEPTH'(issue);
    end
  end

  assign capture_c = (LAT == 0) ? issue : sr_q[DEPTH-1];

endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: initiator-side load/store unit, sole driver of the DM port.
// Accepts single/burst requests (beats = req_len+1) on a valid/ready channel,
// sequences DM strobes and returns read data or a store ack on a valid/ready
// response channel. All outputs are registered.
//   req_*   : request channel (store fills req_wdata into every beat)
//   resp_*  : response channel (rdata=0 for store ack, last on final beat)
//   busy    : sequencer not idle
//   dm_*    : DM address/write_data/mem_write/mem_read/read_data
// Optional build macro DM_LSU_BOUNDS_EN: reject requests whose
// addr+len reaches DM_DEPTH with resp_err=1 and no DM access. Without it
// addresses wrap modulo 2^AW and resp_err is tied to 0.
module dm_lsu
  import dm_pkg::*;
#(
  parameter int unsigned AW         = DM_AW,
  parameter int unsigned DW         = DM_DW,
  parameter int unsigned LENW       = DM_LENW,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned DM_DEPTH   = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [LENW-1:0] req_len,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [DW-1:0]   resp_rdata,
  output logic            resp_last,
  output logic            resp_err,
  output logic            busy,
  output logic [AW-1:0]   dm_address,
  output logic [DW-1:0]   dm_write_data,
  output logic            dm_mem_write,
  output logic            dm_mem_read,
  input  logic [DW-1:0]   dm_read_data
);

  if (RD_LATENCY > RD_LAT_MAX || DM_DEPTH == 0) begin : g_bad_cfg
    $error("dm_lsu: unsupported RD_LATENCY or DM_DEPTH");
  end

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q,  addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [LENW-1:0] len_q,   len_d;
  logic [LENW-1:0] beat_q,  beat_d;
  logic [DW-1:0]   rdata_d;
  logic            last_d;
  logic            accept_c;
  logic            resp_hs_c;
  logic            issue_c;
  logic            capture_c;
  logic            final_beat_c;

`ifdef DM_LSU_BOUNDS_EN
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DM_DEPTH);
  logic err_d;
  logic oob_c;
  // Range test at AW+1 bits so a wrapping burst is caught, not folded.
  assign oob_c = ({1'b0, req_addr} + (AW+1)'(req_len)) >= DEPTH_LIM;
`else
  assign resp_err = 1'b0;
`endif

  assign accept_c     = req_valid && req_ready;
  assign resp_hs_c    = resp_valid && resp_ready;
  assign issue_c      = (state_q == RD_ISSUE);
  assign final_beat_c = (beat_q == len_q);

  // Read-data capture strobe, RD_LATENCY cycles after the issue cycle.
  dm_rd_delay #(
    .LAT (RD_LATENCY)
  ) u_rd_delay (
    .clk       (clk),
    .reset     (reset),
    .issue     (issue_c),
    .capture_c (capture_c)
  );

  // Next-state and next-register logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    beat_d  = beat_q;
    rdata_d = resp_rdata;
    last_d  = resp_last;
`ifdef DM_LSU_BOUNDS_EN
    err_d   = resp_err;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          len_d   = req_len;
          beat_d  = '0;
          last_d  = 1'b0;
          state_d = req_write ? WRITE : RD_ISSUE;
`ifdef DM_LSU_BOUNDS_EN
          err_d   = 1'b0;
          if (oob_c) begin
            state_d = RESP;
            rdata_d = '0;
            last_d  = 1'b1;
            err_d   = 1'b1;
          end
`endif
        end
      end
      WRITE: begin
        if (final_beat_c) begin
          state_d = RESP;
          rdata_d = '0;
          last_d  = 1'b1;
        end else begin
          beat_d = beat_q + LENW'(1);
        end
      end
      RD_ISSUE, RD_WAIT: begin
        state_d = RD_WAIT;
        if (capture_c) begin
          state_d = RESP;
          rdata_d = dm_read_data;
          last_d  = final_beat_c;
        end
      end
      RESP: begin
        if (resp_hs_c) begin
          if (resp_last) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + LENW'(1);
            state_d = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working registers and registered outputs decoded from next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      resp_rdata    <= '0;
      resp_last     <= 1'b0;
      req_ready     <= 1'b0;
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
      dm_mem_write  <= 1'b0;
      dm_mem_read   <= 1'b0;
      dm_address    <= '0;
      dm_write_data <= '0;
`ifdef DM_LSU_BOUNDS_EN
      resp_err      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      resp_rdata    <= rdata_d;
      resp_last     <= last_d;
      req_ready     <= (state_d == IDLE);
      busy          <= (state_d != IDLE);
      resp_valid    <= (state_d == RESP);
      dm_mem_write  <= (state_d == WRITE);
      dm_mem_read   <= (state_d == RD_ISSUE);
      dm_address    <= addr_d + AW'(beat_d);
      dm_write_data <= (state_d == WRITE) ? wdata_d : '0;
`ifdef DM_LSU_BOUNDS_EN
      resp_err      <= err_d;
`endif
    end
  end

endmodule
